// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_delay_line slice: default geometry and a
// constant-foldable ceiling-log2 helper used to size the occupancy counter.
package pipe_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Bits needed to encode 0..value-1; returns 0 for value <= 1.
    function automatic int pipe_clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One WIDTH-bit data register plus valid bit of the delay line.
// PIPE_DELAY_LINE_CLEAR_ON_DISABLE_EN: a disabled edge clears data and valid instead of holding.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_q,
    output logic             o_valid
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    // Flush only invalidates; data keeps its contents so no datapath reset is needed there.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (i_flush) begin
            valid_q <= 1'b0;
        end else if (i_enable) begin
            data_q  <= i_d;
            valid_q <= i_valid;
        end
`ifdef PIPE_DELAY_LINE_CLEAR_ON_DISABLE_EN
        else begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end
`endif
    end

    assign o_q     = data_q;
    assign o_valid = valid_q;

endmodule

// File: rtl/pipe_delay_line.sv
// WIDTH-bit, DEPTH-stage delay line with per-stage valid, stall, flush and registered occupancy.
// PIPE_DELAY_LINE_CLEAR_ON_DISABLE_EN: a disabled edge empties the whole line.
module pipe_delay_line
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = pipe_clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_q,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_fill,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_valid;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] src_data;
            logic             src_valid;
            if (gi == 0) begin : g_head
                assign src_data  = i_d;
                assign src_valid = i_valid;
            end else begin : g_link
                assign src_data  = stage_data[gi-1];
                assign src_valid = stage_valid[gi-1];
            end
            pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .i_clk    (i_clk),
                .i_rst    (i_rst),
                .i_enable (i_enable),
                .i_flush  (i_flush),
                .i_d      (src_data),
                .i_valid  (src_valid),
                .o_q      (stage_data[gi]),
                .o_valid  (stage_valid[gi])
            );
        end
    endgenerate

    logic [CNT_W-1:0] fill_q, fill_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;

    // When full, the last stage is necessarily valid, so the count cannot overflow.
    always_comb begin
        fill_d = fill_q;
        if (i_flush) begin
            fill_d = '0;
        end else if (i_enable) begin
            fill_d = fill_q + CNT_W'(i_valid) - CNT_W'(stage_valid[DEPTH-1]);
        end
`ifdef PIPE_DELAY_LINE_CLEAR_ON_DISABLE_EN
        else begin
            fill_d = '0;
        end
`endif
        full_d  = (fill_d == CNT_W'(DEPTH));
        empty_d = (fill_d == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fill_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            fill_q  <= fill_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign o_q     = stage_data[DEPTH-1];
    assign o_valid = stage_valid[DEPTH-1];
    assign o_fill  = fill_q;
    assign o_full  = full_q;
    assign o_empty = empty_q;

endmodule

// File: tb/tb_pipe_delay_line.sv
// Bench for pipe_delay_line (WIDTH=8, DEPTH=4): directed steps plus random traffic,
// checked against a queue model of the line's contents.
module tb_pipe_delay_line;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_enable = 1'b0;
    logic             i_flush = 1'b0;
    logic [WIDTH-1:0] i_d = '0;
    logic             i_valid = 1'b0;
    logic [WIDTH-1:0] o_q;
    logic             o_valid;
    logic [CNT_W-1:0] o_fill;
    logic             o_full;
    logic             o_empty;

    int checks = 0;
    int errors = 0;

    // Model: entry 0 is the newest sample, entry DEPTH-1 the one on the output.
    logic [WIDTH:0] line_m [$];
    int             max_fill;

    pipe_delay_line #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_enable (i_enable),
        .i_flush  (i_flush),
        .i_d      (i_d),
        .i_valid  (i_valid),
        .o_q      (o_q),
        .o_valid  (o_valid),
        .o_fill   (o_fill),
        .o_full   (o_full),
        .o_empty  (o_empty)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_fill();
        int c = 0;
        foreach (line_m[k]) c += int'(line_m[k][WIDTH]);
        return c;
    endfunction

    task automatic model_edge(input logic rst, input logic flush, input logic en,
                              input logic [WIDTH-1:0] d, input logic v);
        if (rst) begin
            line_m.delete();
            repeat (DEPTH) line_m.push_back('0);
        end else if (flush) begin
            foreach (line_m[k]) line_m[k][WIDTH] = 1'b0;
        end else if (en) begin
            line_m.push_front({v, d});
            void'(line_m.pop_back());
        end else begin
`ifdef PIPE_DELAY_LINE_CLEAR_ON_DISABLE_EN
            foreach (line_m[k]) line_m[k] = '0;
`endif
        end
    endtask

    task automatic step(input logic rst, input logic flush, input logic en,
                        input logic [WIDTH-1:0] d, input logic v);
        int f;
        i_rst = rst; i_flush = flush; i_enable = en; i_d = d; i_valid = v;
        @(posedge i_clk);
        model_edge(rst, flush, en, d, v);
        #1;
        f = model_fill();
        check("q", 32'(o_q), 32'(line_m[DEPTH-1][WIDTH-1:0]));
        check("valid", 32'(o_valid), 32'(line_m[DEPTH-1][WIDTH]));
        check("fill", 32'(o_fill), 32'(f));
        check("full", 32'(o_full), 32'(f == DEPTH));
        check("empty", 32'(o_empty), 32'(f == 0));
        check("fill_bound", 32'(int'(o_fill) <= DEPTH), 32'd1);
        if (f > max_fill) max_fill = f;
        $display("step rst=%0b fl=%0b en=%0b d=%02h v=%0b -> q=%02h v=%0b fill=%0d full=%0b empty=%0b",
                 rst, flush, en, d, v, o_q, o_valid, o_fill, o_full, o_empty);
    endtask

    initial begin
        // Reset held two cycles with live-looking input
        step(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1);
        check("rst_q", 32'(o_q), 32'h00);
        check("rst_empty", 32'(o_empty), 32'd1);

        // Latency: A1 reaches the output after the 4th enabled edge
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'(8'hA1 + i), 1'b1);
            if (i == 3) check("lat_a1", 32'(o_q), 32'hA1);
        end
        check("lat_full", 32'(o_full), 32'd1);

        // Stall three cycles mid-fill
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h10 + i), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'hEE, 1'b1);
`ifdef PIPE_DELAY_LINE_CLEAR_ON_DISABLE_EN
        check("stall_fill", 32'(o_fill), 32'd0);
`else
        check("stall_fill", 32'(o_fill), 32'd3);
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        check("stall_exit", 32'(o_q), 32'h10);
`endif

        // Flush beats enable; 55 is never captured as valid
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h20 + i), 1'b1);
        step(1'b0, 1'b1, 1'b1, 8'h55, 1'b1);
        check("flush_fill", 32'(o_fill), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
            check("flush_no55", 32'(o_valid), 32'd0);
        end

        // Bubbles: valid 1,0,1,0
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        max_fill = 0;
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b0, 1'b1, 8'(i + 1), (i < 4) ? ((i % 2) == 0) : 1'b0);
        check("bubble_max", 32'(max_fill <= 2), 32'd1);

        // Single disabled edge after three valid entries
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h30 + i), 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h77, 1'b1);
`ifdef PIPE_DELAY_LINE_CLEAR_ON_DISABLE_EN
        check("cod_empty", 32'(o_empty), 32'd1);
`else
        check("hold_fill", 32'(o_fill), 32'd3);
`endif

        // Random traffic, including reset mid-stream
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
